// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nco_pkg
//  Brief    : Shared types and constants for the NCO oscillator bank.
//  Revision : 1.0 - initial release
// ============================================================================
package nco_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_OFF = 2'd3
    } wave_e;

    // Low address bit selects the register within a voice.
    localparam logic REG_TW   = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } nco_state_e;

    localparam int         PW_W     = 8;
    localparam logic [7:0] PW_RESET = 8'h80;

endpackage
`default_nettype wire

// File: rtl/nco_wave_shaper.sv
`default_nettype none
// ============================================================================
//  Module   : nco_wave_shaper
//  Brief    : Combinational phase-to-sample converter shared by all voices.
//  Revision : 1.0 - initial release
// ============================================================================
module nco_wave_shaper
    import nco_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 12
) (
    input  logic [ACC_W-1:0] phase,
    input  logic [1:0]       wave,
    input  logic [PW_W-1:0]  pw,
    output logic [OUT_W-1:0] sample
);

    logic [OUT_W-1:0] w_tri_base;
    logic             w_unused;

    // Bits below the triangle window never reach the output.
    assign w_unused   = ^phase[ACC_W-OUT_W-2:0];
    assign w_tri_base = phase[ACC_W-2 -: OUT_W];

    always_comb begin
        sample = '0;
        case (wave)
            WAVE_SAW: sample = phase[ACC_W-1 -: OUT_W];
            WAVE_TRI: sample = phase[ACC_W-1] ? ~w_tri_base : w_tri_base;
            WAVE_SQR: sample = (phase[ACC_W-1 -: PW_W] < pw) ? '1 : '0;
            default:  sample = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : nco_bank
//  Brief    : Time-multiplexed bank of phase-accumulator oscillators with
//             shadowed tuning/control registers and optional hard sync.
//  Revision : 1.0 - initial release
// ============================================================================
module nco_bank
    import nco_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 12,
    parameter int TICK_DIV   = 20
) (
    input  logic             clkNco,
    input  logic             rstN,
    input  logic             wrEn,
    input  logic [2:0]       wrAddr,
    input  logic [ACC_W-1:0] wrData,
    output logic             wrReady,
    input  logic             syncEn,
    output logic             frameStart,
    output logic             sampleValid,
    output logic [1:0]       sampleVoice,
    output logic [OUT_W-1:0] sampleOut
);

    localparam int TICK_W = $clog2(TICK_DIV);

    generate
        if (NUM_VOICES < 1 || NUM_VOICES > 4) begin : g_bad_num_voices
            $error("nco_bank: NUM_VOICES must lie in 1..4");
        end
        if (TICK_DIV < NUM_VOICES + 2) begin : g_bad_tick_div
            $error("nco_bank: TICK_DIV must be at least NUM_VOICES+2");
        end
    endgenerate

    nco_state_e        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        voice_q, voice_d;
    logic              wrap0_q, wrap0_d;
    logic              wr_ready_q, wr_ready_d;
    logic              frame_q, frame_d;
    logic              valid_q, valid_d;
    logic [1:0]        svoice_q, svoice_d;
    logic [OUT_W-1:0]  sout_q, sout_d;

    logic [ACC_W-1:0]  phase_q  [NUM_VOICES];
    logic [ACC_W-1:0]  phase_d  [NUM_VOICES];
    logic [ACC_W-1:0]  tw_sh_q  [NUM_VOICES];
    logic [ACC_W-1:0]  tw_sh_d  [NUM_VOICES];
    logic [ACC_W-1:0]  tw_q     [NUM_VOICES];
    logic [ACC_W-1:0]  tw_d     [NUM_VOICES];
    logic [1:0]        wave_sh_q[NUM_VOICES];
    logic [1:0]        wave_sh_d[NUM_VOICES];
    logic [1:0]        wave_q   [NUM_VOICES];
    logic [1:0]        wave_d   [NUM_VOICES];
    logic [PW_W-1:0]   pw_sh_q  [NUM_VOICES];
    logic [PW_W-1:0]   pw_sh_d  [NUM_VOICES];
    logic [PW_W-1:0]   pw_q     [NUM_VOICES];
    logic [PW_W-1:0]   pw_d     [NUM_VOICES];

    logic              w_tick_last;
    logic              w_wr_accept;
    logic [1:0]        w_wr_voice;
    logic [ACC_W-1:0]  w_cur_phase;
    logic [ACC_W-1:0]  w_cur_tw;
    logic [1:0]        w_cur_wave;
    logic [PW_W-1:0]   w_cur_pw;
    logic [ACC_W-1:0]  w_sum;
    logic              w_carry;
    logic              w_sync_zero;
    logic [ACC_W-1:0]  w_new_phase;
    logic [OUT_W-1:0]  w_shaped;

    assign w_tick_last = (tick_q == TICK_W'(TICK_DIV - 1));
    assign w_wr_accept = wrEn && wr_ready_q;
    assign w_wr_voice  = wrAddr[2:1];

    // Operand select and accumulate for the voice currently in RUN.
    always_comb begin
        w_cur_phase = '0;
        w_cur_tw    = '0;
        w_cur_wave  = WAVE_SAW;
        w_cur_pw    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_q == 2'(v)) begin
                w_cur_phase = phase_q[v];
                w_cur_tw    = tw_q[v];
                w_cur_wave  = wave_q[v];
                w_cur_pw    = pw_q[v];
            end
        end
        {w_carry, w_sum} = {1'b0, w_cur_phase} + {1'b0, w_cur_tw};
        // Voice 0 always runs first, so its wrap flag is current when voice 1 runs.
        w_sync_zero = syncEn && wrap0_q && (voice_q == 2'd1);
        w_new_phase = w_sync_zero ? '0 : w_sum;
    end

    nco_wave_shaper #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_shaper (
        .phase  (w_new_phase),
        .wave   (w_cur_wave),
        .pw     (w_cur_pw),
        .sample (w_shaped)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = w_tick_last ? '0 : tick_q + 1'b1;
        voice_d   = voice_q;
        wrap0_d   = wrap0_q;
        frame_d   = w_tick_last;
        valid_d   = 1'b0;
        svoice_d  = svoice_q;
        sout_d    = sout_q;
        phase_d   = phase_q;
        tw_sh_d   = tw_sh_q;
        tw_d      = tw_q;
        wave_sh_d = wave_sh_q;
        wave_d    = wave_q;
        pw_sh_d   = pw_sh_q;
        pw_d      = pw_q;

        case (state_q)
            ST_IDLE: begin
                if (w_tick_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tw_d    = tw_sh_q;
                wave_d  = wave_sh_q;
                pw_d    = pw_sh_q;
                wrap0_d = 1'b0;
                voice_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (voice_q == 2'(v)) begin
                        phase_d[v] = w_new_phase;
                    end
                end
                if (voice_q == 2'd0) begin
                    wrap0_d = w_carry;
                end
                valid_d  = 1'b1;
                svoice_d = voice_q;
                sout_d   = w_shaped;
                if (voice_q == 2'(NUM_VOICES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    voice_d = voice_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Writes land in the shadow bank; unmatched voice indices fall through.
        if (w_wr_accept) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_wr_voice == 2'(v)) begin
                    if (wrAddr[0] == REG_TW) begin
                        tw_sh_d[v] = wrData;
                    end else begin
                        wave_sh_d[v] = wrData[1:0];
                        pw_sh_d[v]   = wrData[9:2];
                    end
                end
            end
        end

        wr_ready_d = (state_d != ST_LOAD);
    end

    always_ff @(posedge clkNco or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            voice_q    <= '0;
            wrap0_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            frame_q    <= 1'b0;
            valid_q    <= 1'b0;
            svoice_q   <= '0;
            sout_q     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v]   <= '0;
                tw_sh_q[v]   <= '0;
                tw_q[v]      <= '0;
                wave_sh_q[v] <= WAVE_SAW;
                wave_q[v]    <= WAVE_SAW;
                pw_sh_q[v]   <= PW_RESET;
                pw_q[v]      <= PW_RESET;
            end
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            voice_q    <= voice_d;
            wrap0_q    <= wrap0_d;
            wr_ready_q <= wr_ready_d;
            frame_q    <= frame_d;
            valid_q    <= valid_d;
            svoice_q   <= svoice_d;
            sout_q     <= sout_d;
            phase_q    <= phase_d;
            tw_sh_q    <= tw_sh_d;
            tw_q       <= tw_d;
            wave_sh_q  <= wave_sh_d;
            wave_q     <= wave_d;
            pw_sh_q    <= pw_sh_d;
            pw_q       <= pw_d;
        end
    end

    assign wrReady     = wr_ready_q;
    assign frameStart  = frame_q;
    assign sampleValid = valid_q;
    assign sampleVoice = svoice_q;
    assign sampleOut   = sout_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nco_bank
//  Brief    : Directed self-checking bench for the NCO oscillator bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nco_bank;
    import nco_pkg::*;

    localparam int NV = 3;
    localparam int AW = 24;
    localparam int OW = 12;
    localparam int TD = 20;

    localparam logic [OW-1:0] SQ_EXP  [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                                              12'h000, 12'h000, 12'h000, 12'hFFF};
    localparam logic [OW-1:0] TRI_EXP [4] = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
    localparam logic [OW-1:0] V0S_EXP [4] = '{12'h800, 12'h000, 12'h800, 12'h000};
    localparam logic [OW-1:0] V1S_EXP [4] = '{12'h300, 12'h000, 12'h300, 12'h000};

    logic          clk = 1'b0;
    logic          rstN;
    logic          wrEn;
    logic [2:0]    wrAddr;
    logic [AW-1:0] wrData;
    logic          wrReady;
    logic          syncEn;
    logic          frameStart;
    logic          sampleValid;
    logic [1:0]    sampleVoice;
    logic [OW-1:0] sampleOut;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] smp [NV];

    always #5 clk = ~clk;

    nco_bank #(
        .NUM_VOICES (NV),
        .ACC_W      (AW),
        .OUT_W      (OW),
        .TICK_DIV   (TD)
    ) dut (
        .clkNco      (clk),
        .rstN        (rstN),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .wrReady     (wrReady),
        .syncEn      (syncEn),
        .frameStart  (frameStart),
        .sampleValid (sampleValid),
        .sampleVoice (sampleVoice),
        .sampleOut   (sampleOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the LOAD-cycle negedge; n counts idle negedges waited.
    task automatic wait_start(output int n);
        n = 0;
        @(negedge clk);
        while (frameStart !== 1'b1 && n < 2 * TD) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start", 32'(frameStart), 32'd1);
        chk("wr_ready_load", 32'(wrReady), 32'd0);
    endtask

    task automatic read_samples();
        @(negedge clk);
        chk("run0_no_valid", 32'(sampleValid), 32'd0);
        chk("wr_ready_run", 32'(wrReady), 32'd1);
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            wrEn = 1'b0;
            chk("sample_valid", 32'(sampleValid), 32'd1);
            chk("sample_voice", 32'(sampleVoice), 32'(v));
            smp[v] = sampleOut;
        end
        @(negedge clk);
        chk("valid_drop", 32'(sampleValid), 32'd0);
        chk("sample_hold", 32'(sampleOut), 32'(smp[NV-1]));
    endtask

    task automatic frame();
        int n;
        wait_start(n);
        read_samples();
    endtask

    task automatic wr(input logic [1:0] voice, input logic rg, input logic [AW-1:0] data);
        int n = 0;
        while (wrReady !== 1'b1 && n < 2 * TD) begin
            @(negedge clk);
            n++;
        end
        wrEn   = 1'b1;
        wrAddr = {voice, rg};
        wrData = data;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    initial begin
        int n;
        int first;
        int vcount;

        rstN   = 1'b0;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        syncEn = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(wrReady), 32'd0);
        chk("rst_frame", 32'(frameStart), 32'd0);
        chk("rst_valid", 32'(sampleValid), 32'd0);
        chk("rst_voice", 32'(sampleVoice), 32'd0);
        chk("rst_out", 32'(sampleOut), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(wrReady), 32'd1);

        // Idle bank: all-zero samples, 20-cycle frame period
        frame();
        for (int v = 0; v < NV; v++) chk("idle_sample", 32'(smp[v]), 32'd0);
        wait_start(n);
        chk("frame_period", 32'(n), 32'(TD - 6));
        read_samples();

        // Saw ramp; last of two back-to-back writes wins, voice 3 dropped
        wr(2'd0, REG_TW, 24'h700000);
        wr(2'd0, REG_TW, 24'h100000);
        wr(2'd3, REG_TW, 24'hFFFFFF);
        for (int k = 1; k <= 16; k++) begin
            frame();
            chk("saw_v0", 32'(smp[0]), 32'((k * 256) % 4096));
            chk("saw_v1_frozen", 32'(smp[1]), 32'd0);
            chk("saw_v2_frozen", 32'(smp[2]), 32'd0);
        end

        // Square, pw = 0x80
        wr(2'd0, REG_CTRL, 24'h000202);
        wr(2'd0, REG_TW, 24'h200000);
        for (int k = 0; k < 8; k++) begin
            frame();
            chk("sqr_v0", 32'(smp[0]), 32'(SQ_EXP[k]));
        end

        // Triangle on voice 2, voice 0 switched off
        wr(2'd2, REG_CTRL, 24'h000201);
        wr(2'd2, REG_TW, 24'h400000);
        wr(2'd0, REG_CTRL, 24'h000203);
        for (int k = 0; k < 8; k++) begin
            frame();
            chk("tri_v2", 32'(smp[2]), 32'(TRI_EXP[k % 4]));
            chk("off_v0", 32'(smp[0]), 32'd0);
        end

        // Hard sync of voice 1 to voice 0
        wr(2'd0, REG_CTRL, 24'h000200);
        wr(2'd0, REG_TW, 24'h800000);
        wr(2'd1, REG_TW, 24'h300000);
        syncEn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            frame();
            chk("sync_v0", 32'(smp[0]), 32'(V0S_EXP[k]));
            chk("sync_v1", 32'(smp[1]), 32'(V1S_EXP[k]));
            chk("sync_v2_tri", 32'(smp[2]), 32'(TRI_EXP[k]));
        end
        syncEn = 1'b0;

        // Write presented during LOAD is held off and lands in the next frame
        wait_start(n);
        wrEn   = 1'b1;
        wrAddr = {2'd2, REG_TW};
        wrData = 24'h100000;
        read_samples();
        chk("load_wr_old_tw", 32'(smp[2]), 32'h800);
        frame();
        chk("load_wr_new_tw", 32'(smp[2]), 32'hA00);

        // Reset asserted during RUN(1)
        wait_start(n);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("midrst_valid", 32'(sampleValid), 32'd0);
        chk("midrst_out", 32'(sampleOut), 32'd0);
        chk("midrst_voice", 32'(sampleVoice), 32'd0);
        chk("midrst_frame", 32'(frameStart), 32'd0);
        chk("midrst_ready", 32'(wrReady), 32'd0);
        repeat (2) @(negedge clk);
        rstN   = 1'b1;
        first  = -1;
        vcount = 0;
        for (int i = 1; i <= 2 * TD; i++) begin
            @(negedge clk);
            if (sampleValid === 1'b1) vcount++;
            if (frameStart === 1'b1) begin
                first = i;
                break;
            end
        end
        chk("post_rst_first_frame", 32'(first), 32'(TD));
        chk("post_rst_no_valid", 32'(vcount), 32'd0);
        read_samples();
        for (int v = 0; v < NV; v++) chk("post_rst_sample", 32'(smp[v]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nco_bank.md
Name: nco_bank

Overview:
- Time-multiplexed bank of phase-accumulator oscillators for the three MiniMoog VCOs.
- Clocked by the 1 MHz clkNco output of the clock prescaler.
- Tuning and waveform registers are written by the upstream control/SPI decode logic.
- Emits one unsigned sample per voice per sample frame to the downstream mixer.

Parameters:
- NUM_VOICES, 3: oscillators in the bank (1..4).
- ACC_W, 24: phase accumulator and tuning-word width.
- OUT_W, 12: sample width, unsigned offset-binary.
- TICK_DIV, 20: clkNco cycles per sample frame (1 MHz / 20 = 50 kHz). Elaboration error if TICK_DIV < NUM_VOICES+2.

Ports:
- clkNco  in  1  sole clock (1 MHz NCO clock).
- rstN  in  1  reset; asynchronous, active-low.
- wrEn  in  1  register write request.
- wrAddr  in  3  {voice[1:0], reg}; reg 0 = tuning word, reg 1 = control.
- wrData  in  ACC_W  write data; control uses [1:0] wave, [9:2] pulse width.
- wrReady  out  1  write accepted when wrEn && wrReady.
- syncEn  in  1  hard-sync voice 1 to voice 0.
- frameStart  out  1  one-cycle pulse at each frame tick.
- sampleValid  out  1  sample strobe.
- sampleVoice  out  2  voice index of sampleOut.
- sampleOut  out  OUT_W  sample.

Behaviour:
- Reset (async, rstN=0):
  - phases, tuning words (shadow and active) = 0.
  - wave = saw, pw = 0x80.
  - tick counter = 0, FSM = IDLE.
  - outputs 0, wrReady = 0.
  - Reset mid-frame aborts the frame; no partial sampleValid after release.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - At count TICK_DIV-1: frameStart = 1 (registered, next cycle) and FSM enters LOAD.
- FSM, IDLE -> LOAD -> RUN(v=0..NUM_VOICES-1) -> IDLE:
  - LOAD (1 cycle): shadow registers are copied to active. wrReady = 0 in LOAD only; 1 otherwise after reset.
  - RUN, one voice per cycle, in ascending order: phase_next = phase[v] + tw[v] mod 2^ACC_W. wrap = carry out.
- Writes:
  - Accepted writes go to shadow registers only, so they take effect at the next LOAD, never mid-frame.
  - Writes to voice >= NUM_VOICES are accepted and dropped.
  - Same-address writes in consecutive cycles: last write wins.
- Hard sync: if syncEn = 1 and voice 0 wrapped in this frame's RUN, voice 1's stored phase and shaped phase are 0 instead of phase_next. Voice 0 is always processed before voice 1.
- Output timing:
  - The sample for voice v is registered: sampleValid/sampleVoice/sampleOut appear one cycle after RUN(v).
  - Samples are therefore NUM_VOICES consecutive valid cycles per frame.
  - sampleOut is held between strobes.
- Wave shaping, p = updated phase:
  - saw (0): p[ACC_W-1 -: OUT_W].
  - tri (1): p[ACC_W-2 -: OUT_W] if p[ACC_W-1] = 0, else its bitwise inverse.
  - square (2): all-ones if p[ACC_W-1 -: 8] < pw, else 0. pw = 0 gives constant 0.
  - off (3): 0. Phase still advances.
- tw = 0: phase frozen, output constant.

Decomposition:
- nco_pkg holds:
  - wave codes (SAW, TRI, SQR, OFF).
  - register offsets (REG_TW, REG_CTRL).
  - FSM state encoding.
  - reset defaults (PW_RESET = 0x80).
- Sub-module nco_wave_shaper: combinational; (phase, wave, pw) -> sample. Instantiated once and shared across voices by the time multiplexing.

Test Plan:
1. Reset, no writes -> every 20 cycles: frameStart, then sampleValid for 3 cycles with sampleVoice 0, 1, 2 and sampleOut 0x000. wrReady is low only on the LOAD cycle.
2. Voice 0 saw, tw = 0x100000 -> successive voice-0 samples 0x100, 0x200, … 0xF00, 0x000 (wrap at frame 16).
3. Voice 0 square, pw = 0x80, tw = 0x200000 -> samples 0xFFF, 0xFFF, 0xFFF, 0x000, 0x000, 0x000, 0x000, 0xFFF.
4. Voice 2 tri, tw = 0x400000 -> samples 0x800, 0xFFF, 0x7FF, 0x000, repeating.
5. syncEn = 1, v0 tw = 0x800000, v1 tw = 0x300000 -> v1 samples 0x300, 0x000 (v0 wraps in frame 2), 0x300, 0x000.
6. Write presented during LOAD -> held off by wrReady = 0, taken next cycle, and the new tw first affects the following frame. Assert rstN low during RUN(1) -> no further sampleValid until a full frame after release; all outputs 0.
